// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write handshake bundle for fifo_wr_arbiter.
// master = requesters plus FIFO side; slave = the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_rd_en;
  logic           fifo_full;
  logic           fifo_empty;

  modport master (
    output req, req_data, fifo_rd_en, fifo_full, fifo_empty,
    input  gnt, fifo_wr_en, fifo_data_in
  );

  modport slave (
    input  req, req_data, fifo_rd_en, fifo_full, fifo_empty,
    output gnt, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO, with occupancy tracking and flag check.
// Optional per-requester grant counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4,
  parameter int unsigned D = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_arbiter_if.slave    bus,
  output logic [D:0]          count,
  output logic                err,
  output logic [N*8-1:0]      grant_cnt
);

  localparam int unsigned PtrW = $clog2(N);
  localparam logic [D:0] FullCnt = {1'b1, {D{1'b0}}};

  logic [PtrW-1:0] ptr_q;
  logic [D:0]      count_q;
  logic            err_q;

  logic            space;
  logic            found;
  logic            grant;
  logic            rd;
  logic [PtrW-1:0] win;
  int unsigned     scan_idx;

  assign space = (count_q != FullCnt) && !bus.fifo_full;
  assign grant = !rst && space && found;
  assign rd    = bus.fifo_rd_en && (count_q != '0);

  // First requesting index at or after ptr_q, wrapping modulo N.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = (32'(ptr_q) + k) % N;
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        win   = PtrW'(scan_idx);
      end
    end
  end

  always_comb begin
    bus.gnt          = '0;
    bus.fifo_data_in = '0;
    if (grant) begin
      bus.gnt[win]     = 1'b1;
      bus.fifo_data_in = bus.req_data[32'(win)*W +: W];
    end
  end

  assign bus.fifo_wr_en = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        ptr_q <= (win == PtrW'(N - 1)) ? '0 : win + 1'b1;
      end
      unique case ({grant, rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Flags reflect occupancy after the previous edge, i.e. count_q now.
      if (((count_q == '0) != bus.fifo_empty) || ((count_q == FullCnt) != bus.fifo_full)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign count = count_q;
  assign err   = err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [N*8-1:0] grant_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.gnt[i] && (grant_cnt_q[i*8 +: 8] != 8'hFF)) begin
          grant_cnt_q[i*8 +: 8] <= grant_cnt_q[i*8 +: 8] + 8'd1;
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule
